dcm_drp_master: RTL
===================

// Module: dcm_drp_master
// PURPOSE
//   DRP initiator that retunes a DCM's CLKFX ratio at run time: holds DCM in reset,
//   writes M-1/D-1 to DFS register, reads it back to verify, releases reset, waits
//   for LOCKED. Sits in the DCLK domain between the clock-control CSRs and the DCM.
// PARAMETERS
//   DFS_ADDR        7'h50   DRP address of the DFS M/D register
//   RST_HOLD_CYCLES 8       DCLK cycles DCM_RST held before first DRP access (>=1)
//   LOCK_TIMEOUT    1000000 DCLK cycles to wait for LOCKED (used only with macro)
// PORTS
//   DCLK       in   1   DRP/control clock, all logic rising-edge
//   RST_N      in   1   async active-low reset
//   REQ_VALID  in   1   request strobe; accepted when REQ_VALID & REQ_READY
//   REQ_READY  out  1   high only in IDLE
//   REQ_MULT   in   8   CLKFX multiply, legal 2..33
//   REQ_DIV    in   8   CLKFX divide, legal 1..32
//   DONE       out  1   one-cycle completion pulse
//   ERR        out  1   status, valid with DONE, held until next accept
//   DADDR      out  7   DRP address
//   DI         out  16  DRP write data {REQ_MULT-1, REQ_DIV-1}
//   DEN        out  1   DRP enable, one-cycle pulse per access
//   DWE        out  1   DRP write enable, qualified by DEN
//   DO         in   16  DRP read data, valid with DRDY
//   DRDY       in   1   DRP access complete
//   DCM_RST    out  1   DCM reset (active high)
//   LOCKED     in   1   DCM lock indicator (synchronised externally)
// BEHAVIOUR
//   Reset: state IDLE; REQ_READY=1; DONE=ERR=DEN=DWE=DCM_RST=0; DADDR=0; DI=0.
//   Accept: M,D registered on handshake; ERR cleared. Illegal M or D -> next cycle
//     DONE=1, ERR=1, no DRP access, DCM_RST untouched, back to IDLE.
//   FSM: IDLE -> HOLD -> WR -> WR_WAIT -> RD -> RD_WAIT -> RELEASE -> LOCK_WAIT -> FIN -> IDLE.
//   HOLD: DCM_RST=1, counter runs RST_HOLD_CYCLES cycles.
//   WR: DEN=1,DWE=1,DADDR=DFS_ADDR,DI={M-1,D-1} for exactly one cycle.
//   WR_WAIT: DADDR/DI stable, DEN=0; leave on first DRDY.
//   RD: DEN=1,DWE=0 one cycle; RD_WAIT: on DRDY compare DO to written word,
//     mismatch sets ERR (sequence continues so DCM is not left in reset).
//   RELEASE: DCM_RST=0 one cycle later; LOCK_WAIT: exit on LOCKED=1.
//   FIN: DONE=1 one cycle; ERR reflects readback result.
//   DEN never reasserted before DRDY of previous access; DRDY outside *_WAIT ignored.
//   DRDY in same cycle as DEN is ignored (DRP latency >=1).
//   Min latency accept->DONE: RST_HOLD_CYCLES + 6 + DRP latencies + lock time.
//   Async reset mid-sequence: all outputs to reset values at once (DCM_RST drops);
//     late DRDY after reset ignored.
//   REQ_VALID outside IDLE ignored (REQ_READY=0); no queueing.
// CONFIGURATION
//   DCM_LOCK_TIMEOUT_EN defined: LOCK_WAIT counts to LOCK_TIMEOUT; on expiry go to
//     FIN with ERR=1, DCM_RST stays 0.
//   Undefined: LOCK_WAIT waits indefinitely; LOCK_TIMEOUT unused, no counter width cost.
// STRUCTURE
//   dcm_drp_pkg: state enum, DFS field positions (MULT [15:8], DIV [7:0]),
//     legal M/D limits, default DFS_ADDR.
//   No sub-module; one shared down-counter serves HOLD and lock timeout.
// TESTING
//   M=4,D=1, DRDY after 3 cycles, DO echoes DI, LOCKED after 50 -> DI=16'h0300,
//     one DEN write + one DEN read, DONE=1 ERR=0.
//   M=1 or D=0 or M=34 -> DONE+ERR next cycle, DEN never asserted, DCM_RST=0.
//   Readback DO=16'hFFFF vs written 16'h0300 -> ERR=1, DCM_RST still released, DONE pulses.
//   REQ_VALID held high during sequence -> second request only after DONE, REQ_READY=0 throughout.
//   RST_N low during WR_WAIT -> DCM_RST=0, REQ_READY=1 immediately; stray DRDY ignored.
//   With DCM_LOCK_TIMEOUT_EN, LOCK_TIMEOUT=100, LOCKED stuck 0 -> DONE+ERR 100 cycles after release.

Source files
------------

// File: rtl/dcm_drp_pkg.sv
// Shared types and constants for the DCM DRP retune master.
// Holds the DFS register layout, the legal CLKFX M/D ranges and the FSM state encoding.
package dcm_drp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WR,
    ST_WR_WAIT,
    ST_RD,
    ST_RD_WAIT,
    ST_RELEASE,
    ST_LOCK_WAIT,
    ST_FIN
  } state_t;

  localparam logic [6:0] DFS_ADDR_DEFAULT = 7'h50;

  localparam int DFS_MULT_MSB = 15;
  localparam int DFS_MULT_LSB = 8;
  localparam int DFS_DIV_MSB  = 7;
  localparam int DFS_DIV_LSB  = 0;

  localparam logic [7:0] MULT_MIN = 8'd2;
  localparam logic [7:0] MULT_MAX = 8'd33;
  localparam logic [7:0] DIV_MIN  = 8'd1;
  localparam logic [7:0] DIV_MAX  = 8'd32;

  function automatic logic md_legal(input logic [7:0] m, input logic [7:0] d);
    return (m >= MULT_MIN) && (m <= MULT_MAX) && (d >= DIV_MIN) && (d <= DIV_MAX);
  endfunction

  // The DFS register stores both ratios minus one.
  function automatic logic [15:0] dfs_word(input logic [7:0] m, input logic [7:0] d);
    logic [15:0] w;
    w = '0;
    w[DFS_MULT_MSB:DFS_MULT_LSB] = m - 8'd1;
    w[DFS_DIV_MSB:DFS_DIV_LSB]   = d - 8'd1;
    return w;
  endfunction

endpackage

// File: rtl/dcm_drp_master.sv
// DRP initiator: holds the DCM in reset, writes/verifies the DFS M/D word, releases and waits for LOCKED.
// Latency RST_HOLD_CYCLES + 6 + two DRP round trips + lock time; REQ_READY only in IDLE, no queueing.
// Optional lock timeout under macro DCM_LOCK_TIMEOUT_EN (otherwise LOCK_WAIT waits forever).
module dcm_drp_master
  import dcm_drp_pkg::*;
#(
  parameter logic [6:0] DFS_ADDR        = DFS_ADDR_DEFAULT,
  parameter int         RST_HOLD_CYCLES = 8,
  parameter int         LOCK_TIMEOUT    = 1000000
) (
  input  logic        DCLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [7:0]  REQ_MULT,
  input  logic [7:0]  REQ_DIV,
  output logic        DONE,
  output logic        ERR,
  output logic [6:0]  DADDR,
  output logic [15:0] DI,
  output logic        DEN,
  output logic        DWE,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        DCM_RST,
  input  logic        LOCKED
);

  if (RST_HOLD_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_param_check
    $error("dcm_drp_master: RST_HOLD_CYCLES and LOCK_TIMEOUT must be >= 1");
  end

  // One down-counter covers the reset hold and, when enabled, the lock timeout.
`ifdef DCM_LOCK_TIMEOUT_EN
  localparam int CNT_MAX = (LOCK_TIMEOUT > RST_HOLD_CYCLES) ? LOCK_TIMEOUT : RST_HOLD_CYCLES;
`else
  localparam int CNT_MAX = RST_HOLD_CYCLES;
`endif
  localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD_CYCLES - 1);
`ifdef DCM_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_TIMEOUT - 1);
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   word_q;

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      word_q    <= '0;
      REQ_READY <= 1'b1;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      DADDR     <= '0;
      DI        <= '0;
      DEN       <= 1'b0;
      DWE       <= 1'b0;
      DCM_RST   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            ERR <= 1'b0;
            if (md_legal(REQ_MULT, REQ_DIV)) begin
              word_q    <= dfs_word(REQ_MULT, REQ_DIV);
              cnt       <= HOLD_LOAD;
              DCM_RST   <= 1'b1;
              REQ_READY <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              // Rejected without touching the DRP or the DCM reset.
              DONE <= 1'b1;
              ERR  <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            DEN   <= 1'b1;
            DWE   <= 1'b1;
            DADDR <= DFS_ADDR;
            DI    <= word_q;
            state <= ST_WR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WR: begin
          DEN   <= 1'b0;
          DWE   <= 1'b0;
          state <= ST_WR_WAIT;
        end

        ST_WR_WAIT: begin
          if (DRDY) begin
            DEN   <= 1'b1;
            state <= ST_RD;
          end
        end

        ST_RD: begin
          DEN   <= 1'b0;
          state <= ST_RD_WAIT;
        end

        // A bad readback is flagged but the DCM is still released.
        ST_RD_WAIT: begin
          if (DRDY) begin
            if (DO != DI) ERR <= 1'b1;
            state <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          DCM_RST <= 1'b0;
`ifdef DCM_LOCK_TIMEOUT_EN
          cnt     <= LOCK_LOAD;
`endif
          state   <= ST_LOCK_WAIT;
        end

        ST_LOCK_WAIT: begin
          if (LOCKED) begin
            DONE  <= 1'b1;
            state <= ST_FIN;
          end
`ifdef DCM_LOCK_TIMEOUT_EN
          else if (cnt == '0) begin
            DONE  <= 1'b1;
            ERR   <= 1'b1;
            state <= ST_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end

        ST_FIN: begin
          REQ_READY <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          DEN       <= 1'b0;
          DWE       <= 1'b0;
          REQ_READY <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
